// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-segment driver with frame-synchronous digit buffering,
// leading-zero blanking and an anode-off gap between digit slots.
module seven_seg_scanner #(
  parameter int DIV_CYCLES = 100000,
  parameter int GAP_CYCLES = 1000,
  parameter int CNT_W      = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd_thousands,
  input  logic [3:0] bcd_hundreds,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  input  logic       load,
  input  logic       blank_lz,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  typedef enum logic {S_GAP, S_ON} state_e;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(DIV_CYCLES - GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             init_q, init_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0][3:0]  pend_q, pend_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic             pend_valid_q, pend_valid_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fd_q, fd_d;

  logic [3:0][3:0]  live;
  logic [3:0]       blanked;
  logic             boundary;

  assign live = {bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones};

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    init_d       = init_q;
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    boundary     = 1'b0;
    blanked      = 4'b0000;
    an_d         = 4'hF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;

    case (state_q)
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
          init_d  = 1'b0;
          // The start-up gap after reset leads into digit 0 without advancing.
          if (!init_q) idx_d = idx_q + 2'd1;
          boundary = (idx_q == 2'd3) && !init_q;
        end
      end
    endcase

    if (boundary) begin
      if (load) begin
        shadow_d    = live;
        shadow_dp_d = dp_mask;
      end else if (pend_valid_q) begin
        shadow_d    = pend_q;
        shadow_dp_d = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_d       = live;
      pend_dp_d    = dp_mask;
      pend_valid_d = 1'b1;
    end

    blanked[3] = blank_lz && (shadow_d[3] == 4'd0);
    for (int k = 2; k >= 1; k--) blanked[k] = blanked[k+1] && (shadow_d[k] == 4'd0);

    // Outputs come from next-state values so they are valid on the first cycle of a state.
    if (state_d == S_ON) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = blanked[idx_d] ? 7'h7F : decode(shadow_d[idx_d]);
      dp_d  = ~shadow_dp_d[idx_d];
    end
    fd_d = boundary;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q      <= S_GAP;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      init_q       <= 1'b1;
      // NOTE: the digit buffers are tiny and must read as zero after reset, so they are reset too.
      shadow_q     <= '0;
      shadow_dp_q  <= 4'b0000;
      pend_q       <= '0;
      pend_dp_q    <= 4'b0000;
      pend_valid_q <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      fd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      init_q       <= init_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fd_q         <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised and directed stimulus for seven_seg_scanner, checked every cycle
// against a timeline model derived from cycle count since reset.
module tb_seven_seg_scanner;

  localparam int DIV = 8;
  localparam int GAP = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones;
  logic       load, blank_lz;
  logic [3:0] dp_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_done;

  seven_seg_scanner #(.DIV_CYCLES(DIV), .GAP_CYCLES(GAP), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .bcd_thousands(bcd_thousands), .bcd_hundreds(bcd_hundreds),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .load(load), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: cycles since reset release, displayed and pending digits.
  int         t = 0;
  logic [3:0] m_shadow [4];
  logic [3:0] m_shadow_dp;
  logic [3:0] m_pend [4];
  logic [3:0] m_pend_dp;
  logic       m_pv;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_fd;
  logic       armed = 1'b0;
  logic [6:0] dec_tab [16];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d after reset)", tag, got, exp, t);
    end
  endtask

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  end

  always @(posedge clk) begin
    logic [3:0] lv [4];
    logic       bnd, blk;
    logic       bl [4];
    int         u, idx;
    lv = '{bcd_ones, bcd_tens, bcd_hundreds, bcd_thousands};
    if (!rst_n) begin
      t = 0;
      for (int i = 0; i < 4; i++) begin m_shadow[i] = 4'd0; m_pend[i] = 4'd0; end
      m_shadow_dp = 4'd0; m_pend_dp = 4'd0; m_pv = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      bnd = (t >= GAP) && ((t - GAP) % FRAME == FRAME - 1);
      if (bnd) begin
        if (load) begin m_shadow = lv; m_shadow_dp = dp_mask; end
        else if (m_pv) begin m_shadow = m_pend; m_shadow_dp = m_pend_dp; end
        m_pv = 1'b0;
      end else if (load) begin
        m_pend = lv; m_pend_dp = dp_mask; m_pv = 1'b1;
      end
      t++;
      e_fd = bnd;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (t >= GAP) begin
        u   = t - GAP;
        idx = (u / DIV) % 4;
        if (u % DIV < DIV - GAP) begin
          // Leading zeros: blank from the left while digits are zero.
          blk = blank_lz;
          for (int k = 3; k >= 0; k--) begin
            blk   = blk && (m_shadow[k] == 4'd0) && (k != 0);
            bl[k] = blk;
          end
          e_an  = ~(4'b0001 << idx);
          e_seg = bl[idx] ? 7'h7F : dec_tab[m_shadow[idx]];
          e_dp  = ~m_shadow_dp[idx];
        end
      end
    end
    armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("an", {4'h0, an}, {4'h0, e_an});
      check("seg", {1'b0, seg}, {1'b0, e_seg});
      check("dp", {7'h0, dp}, {7'h0, e_dp});
      check("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_load(input logic [3:0] d3, d2, d1, d0, input logic [3:0] m);
    bcd_thousands = d3; bcd_hundreds = d2; bcd_tens = d1; bcd_ones = d0;
    dp_mask = m; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_frame_done();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      step(1);
      seen = (frame_done === 1'b1);
    end
    check("frame_done_wait", {7'h0, seen}, 8'h01);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; blank_lz = 1'b1; dp_mask = 4'h0;
    bcd_thousands = 4'd0; bcd_hundreds = 4'd0; bcd_tens = 4'd0; bcd_ones = 4'd0;
    step(3);
    rst_n = 1'b1;
    step(40);

    blank_lz = 1'b0;
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 4'h0);
    step(80);

    blank_lz = 1'b1;
    do_load(4'd0, 4'd0, 4'd4, 4'd7, 4'h0);
    step(70);
    do_load(4'd0, 4'd1, 4'd0, 4'd0, 4'h0);
    step(70);

    do_load(4'd5, 4'd6, 4'd7, 4'hC, 4'b0100);
    step(70);

    wait_frame_done();
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 4'h0);
    step(5);
    do_load(4'd5, 4'd6, 4'd7, 4'd8, 4'h1);
    step(70);

    // Load held exactly on the frame boundary cycle.
    wait_frame_done();
    step(FRAME - 1);
    do_load(4'd9, 4'd0, 4'd2, 4'd1, 4'h8);
    step(40);

    // Reset during ON of digit 2 drops the pending load.
    wait_frame_done();
    do_load(4'd3, 4'd3, 4'd3, 4'd3, 4'hF);
    step(16);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(70);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bcd_thousands = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bcd_hundreds  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bcd_tens      = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bcd_ones      = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp_mask       = 4'($urandom_range(0, 15));
        load          = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      step(1);
      load  = 1'b0;
      rst_n = 1'b1;
    end
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
